// File: rtl/fetch_decode_stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Runs a req/ack handshake with instruction memory. A one-entry skid buffer
// absorbs a word that returns while decode is stalled. Branch redirects
// flush IF/ID and either retarget immediately or squash the in-flight fetch.
module fetch_decode_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [25:0] seu_address,
  output logic [1:0]  seu_sel
);

  // HOLD means the skid buffer is full and no request is outstanding.
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        imem_req_reg, imem_req_next;
  logic [63:0] imem_addr_reg, imem_addr_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [63:0] id_pc_reg, id_pc_next;
  logic [1:0]  seu_sel_reg, seu_sel_next;
  logic        squash_reg, squash_next;
  logic [63:0] target_reg, target_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [63:0] skid_pc_reg, skid_pc_next;

  logic        slot_free;
  logic        load_en;
  logic [31:0] load_instr;
  logic [63:0] load_pc;
  logic [63:0] seq_addr;

  // Extension mode for the sign-extend unit, from the opcode field.
  function automatic logic [1:0] decode_sel(input logic [31:0] w);
    logic [1:0] s;
    s = 2'b00;
    if (w[31:26] == 6'b000101)
      s = 2'b10;                                   // B
    else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101 ||
             w[31:24] == 8'b01010100)
      s = 2'b11;                                   // CBZ / CBNZ / B.cond
    else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000)
      s = 2'b01;                                   // LDUR / STUR
    return s;
  endfunction

  // Sequential fetch address; wraps silently modulo 2^64.
  assign seq_addr  = imem_addr_reg + 64'(PC_STEP);
  assign slot_free = !id_valid_reg || !stall;

  // Next-state and datapath control; redirect overrides ack and stall.
  always_comb begin
    state_next      = state_reg;
    imem_req_next   = imem_req_reg;
    imem_addr_next  = imem_addr_reg;
    id_valid_next   = id_valid_reg;
    id_instr_next   = id_instr_reg;
    id_pc_next      = id_pc_reg;
    seu_sel_next    = seu_sel_reg;
    squash_next     = squash_reg;
    target_next     = target_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    load_en         = 1'b0;
    load_instr      = imem_rdata;
    load_pc         = imem_addr_reg;

    // Decode consumes the current entry whenever it is not stalling.
    if (!stall)
      id_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Only reachable from reset, so fetch starts at RESET_PC.
        imem_req_next  = 1'b1;
        imem_addr_next = redirect ? redirect_pc : RESET_PC;
        state_next     = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          if (imem_ack) begin
            imem_addr_next = redirect_pc;
            squash_next    = 1'b0;
          end else begin
            // Keep the request stable; drop its data when it returns.
            squash_next = 1'b1;
            target_next = redirect_pc;
          end
        end else if (imem_ack) begin
          if (squash_reg) begin
            imem_addr_next = target_reg;
            squash_next    = 1'b0;
          end else if (slot_free) begin
            load_en        = 1'b1;
            imem_addr_next = seq_addr;
          end else begin
            skid_instr_next = imem_rdata;
            skid_pc_next    = imem_addr_reg;
            imem_req_next   = 1'b0;
            imem_addr_next  = seq_addr;
            state_next      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          imem_req_next  = 1'b1;
          imem_addr_next = redirect_pc;
          state_next     = WAIT;
        end else if (!stall) begin
          // imem_addr already points past the skid word.
          load_en       = 1'b1;
          load_instr    = skid_instr_reg;
          load_pc       = skid_pc_reg;
          imem_req_next = 1'b1;
          state_next    = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_en) begin
      id_valid_next = 1'b1;
      id_instr_next = load_instr;
      id_pc_next    = load_pc;
      seu_sel_next  = decode_sel(load_instr);
    end

    if (redirect)
      id_valid_next = 1'b0;
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      imem_req_reg   <= 1'b0;
      imem_addr_reg  <= 64'h0;
      id_valid_reg   <= 1'b0;
      id_instr_reg   <= 32'h0;
      id_pc_reg      <= 64'h0;
      seu_sel_reg    <= 2'b00;
      squash_reg     <= 1'b0;
      target_reg     <= 64'h0;
      skid_instr_reg <= 32'h0;
      skid_pc_reg    <= 64'h0;
    end else begin
      state_reg      <= state_next;
      imem_req_reg   <= imem_req_next;
      imem_addr_reg  <= imem_addr_next;
      id_valid_reg   <= id_valid_next;
      id_instr_reg   <= id_instr_next;
      id_pc_reg      <= id_pc_next;
      seu_sel_reg    <= seu_sel_next;
      squash_reg     <= squash_next;
      target_reg     <= target_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = imem_addr_reg;
  assign id_valid    = id_valid_reg;
  assign id_instr    = id_instr_reg;
  assign id_pc       = id_pc_reg;
  assign seu_sel     = seu_sel_reg;
  assign seu_address = id_instr_reg[25:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: behavioural instruction memory
// with programmable latency and ack budget, plus an in-order scoreboard of
// the instructions expected to appear in IF/ID.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [25:0] seu_address;
  logic [1:0]  seu_sel;

  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .seu_address(seu_address), .seu_sel(seu_sel)
  );

  always #5 clk = ~clk;

  // Instruction image: eight encodings cycling with address bits [4:2].
  function automatic logic [31:0] base_word(input logic [2:0] idx);
    case (idx)
      3'd0: return 32'h91000421;  // ADDI
      3'd1: return 32'hF8400020;  // LDUR
      3'd2: return 32'h14000010;  // B
      3'd3: return 32'hB4000040;  // CBZ
      3'd4: return 32'hF8000020;  // STUR
      3'd5: return 32'h54000041;  // B.cond
      3'd6: return 32'hB5000060;  // CBNZ
      default: return 32'h8B020020;  // ADD
    endcase
  endfunction

  function automatic logic [1:0] base_sel(input logic [2:0] idx);
    case (idx)
      3'd0: return 2'b00;
      3'd1: return 2'b01;
      3'd2: return 2'b10;
      3'd3: return 2'b11;
      3'd4: return 2'b01;
      3'd5: return 2'b11;
      3'd6: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return base_word(a[4:2]) ^ {11'b0, a[22:8], 6'b0};
  endfunction

  // Memory model: ack once the request has been visible for lat cycles,
  // and only while fewer than 'granted' acks have been given since reset.
  int lat;
  int granted;
  int acks_done;
  int wait_cnt;

  always_comb begin
    imem_ack   = imem_req && ((wait_cnt + 1) >= lat) && (acks_done < granted);
    imem_rdata = mem_word(imem_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acks_done <= 0;
      wait_cnt  <= 0;
    end else begin
      if (imem_ack) acks_done <= acks_done + 1;
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
    end
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [1:0]  sel;
  } item_t;

  item_t sb[$];
  item_t last;
  int    vectors = 0;
  int    miscompares = 0;
  int    items_seen = 0;
  logic  pv, ps, pr;

  task automatic expect_pc(input logic [63:0] pc);
    item_t it;
    it.pc    = pc;
    it.instr = mem_word(pc);
    it.sel   = base_sel(pc[4:2]);
    sb.push_back(it);
  endtask

  // Advance one clock; at the following falling edge check IF/ID against
  // the scoreboard (new entry) or against the previous entry (held by stall).
  task automatic step();
    item_t it;
    pv = id_valid; ps = stall; pr = redirect;
    @(posedge clk);
    @(negedge clk);
    if (pv === 1'b1 && ps === 1'b1 && pr === 1'b0) begin
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== last.pc || id_instr !== last.instr) begin
        miscompares++;
        $display("FAIL hold: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 id_valid, id_pc, id_instr, last.pc, last.instr);
      end
    end else if (id_valid === 1'b1) begin
      vectors++;
      items_seen++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_item: got pc=%h instr=%h expected no valid entry", id_pc, id_instr);
      end else begin
        it = sb.pop_front();
        last = it;
        if ({id_pc, id_instr, seu_sel, seu_address} !== {it.pc, it.instr, it.sel, it.instr[25:0]}) begin
          miscompares++;
          $display("FAIL ifid: got pc=%h instr=%h sel=%b addr=%h expected pc=%h instr=%h sel=%b addr=%h",
                   id_pc, id_instr, seu_sel, seu_address, it.pc, it.instr, it.sel, it.instr[25:0]);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until IF/ID shows the given PC, bounded by a cycle budget.
  task automatic wait_item(input logic [63:0] pc, input int budget);
    int n;
    n = 0;
    while (!(id_valid === 1'b1 && id_pc === pc) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (!(id_valid === 1'b1 && id_pc === pc)) begin
      miscompares++;
      $display("FAIL wait_item: got v=%b pc=%h expected v=1 pc=%h within %0d cycles",
               id_valid, id_pc, pc, budget);
    end
  endtask

  task automatic apply_reset(input int l, input int g);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    lat = l; granted = g;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset(1, 2);
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc, seu_sel} !== 164'h0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b addr=%h v=%b instr=%h pc=%h sel=%b expected all zero",
               imem_req, imem_addr, id_valid, id_instr, id_pc, seu_sel);
    end
    expect_pc(64'h0);
    expect_pc(64'h4);
    rst_n = 1'b1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL req_before_edge: got %b expected 0", imem_req);
    end
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    run(6);
    vectors++;
    if (sb.size() != 0 || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drain: got left=%0d v=%b expected left=0 v=0", sb.size(), id_valid);
    end
  endtask

  task automatic test_latency();
    int seen0;
    apply_reset(3, 3);
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8);
    rst_n = 1'b1;
    step();
    seen0 = items_seen;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0 || id_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_hold[%0d]: got req=%b addr=%h v=%b expected req=1 addr=0 v=0",
                 i, imem_req, imem_addr, id_valid);
      end
      step();
    end
    vectors++;
    if (imem_addr !== 64'h4) begin
      miscompares++;
      $display("FAIL latency_advance: got addr=%h expected 4", imem_addr);
    end
    run(12);
    vectors++;
    if (items_seen - seen0 != 3 || sb.size() != 0 || imem_addr !== 64'hC) begin
      miscompares++;
      $display("FAIL latency_count: got items=%0d left=%0d addr=%h expected items=3 left=0 addr=c",
               items_seen - seen0, sb.size(), imem_addr);
    end
  endtask

  task automatic test_stall_skid();
    apply_reset(2, 4);
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8); expect_pc(64'hC);
    rst_n = 1'b1;
    wait_item(64'h0, 10);
    stall = 1'b1;
    run(2);
    vectors++;
    if (imem_req !== 1'b0 || id_instr !== mem_word(64'h0)) begin
      miscompares++;
      $display("FAIL skid_entry: got req=%b instr=%h expected req=0 instr=%h",
               imem_req, id_instr, mem_word(64'h0));
    end
    run(2);
    vectors++;
    if (imem_req !== 1'b0 || id_pc !== 64'h0) begin
      miscompares++;
      $display("FAIL skid_hold: got req=%b pc=%h expected req=0 pc=0", imem_req, id_pc);
    end
    stall = 1'b0;
    step();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 64'h4 || imem_req !== 1'b1 || imem_addr !== 64'h8) begin
      miscompares++;
      $display("FAIL skid_release: got v=%b pc=%h req=%b addr=%h expected v=1 pc=4 req=1 addr=8",
               id_valid, id_pc, imem_req, imem_addr);
    end
    run(12);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL skid_drain: got left=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_redirect_pending(input logic twice);
    logic [63:0] tgt;
    int n;
    tgt = twice ? 64'h200 : 64'h100;
    apply_reset(3, 5);
    expect_pc(64'h0); expect_pc(64'h4);
    rst_n = 1'b1;
    wait_item(64'h4, 20);
    redirect = 1'b1; redirect_pc = 64'h100;
    step();
    vectors++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8) begin
      miscompares++;
      $display("FAIL squash_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=8",
               id_valid, imem_req, imem_addr);
    end
    if (twice) begin
      redirect_pc = 64'h200;
      step();
      vectors++;
      if (imem_addr !== 64'h8) begin
        miscompares++;
        $display("FAIL squash_second: got addr=%h expected 8", imem_addr);
      end
    end
    redirect = 1'b0;
    expect_pc(tgt); expect_pc(tgt + 64'h4);
    n = 0;
    while (imem_addr === 64'h8 && n < 10) begin
      step();
      n++;
    end
    vectors++;
    if (imem_addr !== tgt || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_target: got addr=%h v=%b expected addr=%h v=0", imem_addr, id_valid, tgt);
    end
    run(15);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL squash_drain: got left=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_flush_priority();
    apply_reset(1, 6);
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8);
    rst_n = 1'b1;
    wait_item(64'h8, 10);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
    step();
    vectors++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
      miscompares++;
      $display("FAIL flush_priority: got v=%b req=%b addr=%h expected v=0 req=1 addr=40",
               id_valid, imem_req, imem_addr);
    end
    stall = 1'b0; redirect = 1'b0;
    expect_pc(64'h40); expect_pc(64'h44);
    run(10);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL flush_drain: got left=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset(1, 5);
    rst_n = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    redirect = 1'b0;
    vectors++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8 || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_target: got addr=%h v=%b expected addr=fffffffffffffff8 v=0", imem_addr, id_valid);
    end
    expect_pc(64'hFFFF_FFFF_FFFF_FFF8); expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
    expect_pc(64'h0); expect_pc(64'h4);
    run(10);
    vectors++;
    if (sb.size() != 0 || imem_addr !== 64'h8) begin
      miscompares++;
      $display("FAIL wrap_drain: got left=%0d addr=%h expected left=0 addr=8", sb.size(), imem_addr);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(3, 10);
    expect_pc(64'h0);
    rst_n = 1'b1;
    wait_item(64'h0, 10);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc, seu_sel, seu_address} !== 190'h0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h pc=%h sel=%b expected all zero",
               imem_req, imem_addr, id_valid, id_instr, id_pc, seu_sel);
    end
    @(negedge clk);
    sb.delete();
    granted = 2;
    expect_pc(64'h0); expect_pc(64'h4);
    rst_n = 1'b1;
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    run(15);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL restart_drain: got left=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall_skid();
    test_redirect_pending(1'b0);
    test_redirect_pending(1'b1);
    test_flush_priority();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the LEGv8 core.
- Holds the PC and runs a req/ack handshake with instruction memory. Absorbs memory wait states, downstream stalls and branch redirects.
- Presents the fetched instruction to decode: its immediate field and extension-mode select drive the sign-extend unit directly.

Parameters:
- RESET_PC, 64'h0, fetch address used after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  64  fetch byte address, registered
- imem_ack  in  1  read data valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word
- stall  in  1  decode not accepting; hold IF/ID contents
- redirect  in  1  taken branch: flush and refetch
- redirect_pc  in  64  branch target
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  instruction word
- id_pc  out  64  address of id_instr
- seu_address  out  26  id_instr[25:0] to sign-extend unit
- seu_sel  out  2  extension mode: 00 ALU-imm, 01 DT, 10 B, 11 CB

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=0.
  - id_valid=0, id_instr=0, id_pc=0, seu_sel=00.
  - squash=0, skid empty.
- States: IDLE, WAIT (request outstanding), HOLD (skid full, no request).
- IDLE:
  - Next edge: imem_req=1, imem_addr=fetch_pc (or redirect_pc if redirect=1), go WAIT.
  - First request is visible one cycle after rst_n rises.
- WAIT:
  - imem_req and imem_addr stay stable until imem_ack; an ack in the same cycle the request is raised is legal.
  - Slot free at an edge = !id_valid || !stall.
- WAIT, ack=1, squash=0:
  - If slot free: IF/ID loads {imem_rdata, imem_addr}, id_valid=1, imem_addr advances by PC_STEP, stay WAIT. Zero-wait memory gives one instruction per cycle.
  - If slot not free: word goes to the skid register, imem_req=0, go HOLD.
- HOLD:
  - When stall=0: skid moves to IF/ID (id_valid=1), imem_req=1 at the next sequential address, go WAIT.
- Redirect (priority over stall and ack):
  - id_valid=0 and skid cleared at the same edge.
  - IDLE or HOLD: imem_addr=redirect_pc, imem_req=1, go WAIT.
  - WAIT with ack=1 in the same cycle: returned word discarded, imem_addr=redirect_pc.
  - WAIT with ack=0: request stays stable; squash=1, target latched. A later redirect while squash=1 overwrites the target.
  - Ack arriving with squash=1: word discarded, imem_addr=target, squash=0, stay WAIT.
- seu_sel is registered with id_instr, decoded from the incoming word:
  - bits[31:26]=000101 → 10.
  - bits[31:24] ∈ {10110100, 10110101, 01010100} → 11.
  - bits[31:21] ∈ {11111000010, 11111000000} → 01.
  - else 00.
- seu_address is combinational: id_instr[25:0].
- While id_valid=0, IF/ID data contents are don't-care but must not change except on a load.
- PC arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is silent.

Test Plan:
- Reset release with ack tied to req, words 0x91000421, 0xF8400020 at PC 0,4 → req high 1 cycle after reset. id_valid, id_pc=0, seu_sel=00 one edge after the first ack. Next cycle id_pc=4, seu_sel=01.
- Memory with 3-cycle ack latency → imem_addr holds 0 for 3 cycles. id_valid pulses once per ack; no duplicate or skipped PC.
- stall=1 for 4 cycles while id_valid=1 and a fetch is outstanding → ack word goes to the skid, req drops, id_instr unchanged. On stall=0, the skid word appears next edge and req resumes at the following PC.
- redirect=1 to 0x100 while a request to 0x8 awaits ack (ack 2 cycles later) → id_valid=0 immediately. Ack data for 0x8 never appears in IF/ID; next request address is 0x100.
- redirect, stall and ack all in the same cycle → flush wins: id_valid=0, ack word dropped, imem_addr=redirect_pc.
- rst_n asserted mid-WAIT → all outputs at reset values without a clock edge. Refetch restarts at RESET_PC.
